// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the sequence detector: takes words over a
// valid/ready handshake and emits them one bit per clock on x_out.
module bit_serializer #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter bit          IDLE_BIT   = 1'b0,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             x_out,
   output logic             x_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int unsigned CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam bit          NO_GAP   = (GAP_CYCLES == 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
   logic             x_out_d, x_valid_d, frame_start_d, busy_d;
   logic             last_bit, accept;
   logic             first_bit, next_bit;
   logic [WIDTH-1:0] load_word, shift_word;

   assign last_bit = (state_q == S_SHIFT) && (bit_cnt_q == CW'(WIDTH - 1));
   assign in_ready = reset & ((state_q == S_IDLE) | (last_bit & NO_GAP));
   assign accept   = in_valid & in_ready;

   // The shift register holds the bits still to be sent after the one on x_out
   assign first_bit  = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
   assign load_word  = MSB_FIRST ? {in_data[WIDTH-2:0], 1'b0} : {1'b0, in_data[WIDTH-1:1]};
   assign next_bit   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
   assign shift_word = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

   // State register and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         x_out       <= IDLE_BIT;
         x_valid     <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         x_out       <= x_out_d;
         x_valid     <= x_valid_d;
         frame_start <= frame_start_d;
         busy        <= busy_d;
      end
   end

   // Next-state and next-output logic; an accept always starts a fresh frame
   always_comb begin
      state_d       = state_q;
      shreg_d       = shreg_q;
      bit_cnt_d     = bit_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      x_out_d       = IDLE_BIT;
      x_valid_d     = 1'b0;
      frame_start_d = 1'b0;

      if (accept) begin
         state_d       = S_SHIFT;
         shreg_d       = load_word;
         bit_cnt_d     = '0;
         x_out_d       = first_bit;
         x_valid_d     = 1'b1;
         frame_start_d = 1'b1;
      end else begin
         case (state_q)
            S_SHIFT: begin
               if (!last_bit) begin
                  x_out_d   = next_bit;
                  x_valid_d = 1'b1;
                  shreg_d   = shift_word;
                  bit_cnt_d = bit_cnt_q + CW'(1);
               end else if (!NO_GAP) begin
                  state_d   = S_GAP;
                  gap_cnt_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_GAP: begin
               if (gap_cnt_q == GW'(GAP_LAST)) begin
                  state_d = S_IDLE;
               end else begin
                  gap_cnt_d = gap_cnt_q + GW'(1);
               end
            end
            S_IDLE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: two instances (MSB-first/no gap, LSB-first/2-cycle gap)
// compared every cycle against a word-level reference model.
module tb_bit_serializer;

   localparam bit MSBF  [2] = '{1'b1, 1'b0};
   localparam bit IDLEB [2] = '{1'b0, 1'b1};
   localparam int GAPC  [2] = '{0, 2};

   logic       clk, reset;
   logic [7:0] din0, din1;
   logic       vin0, vin1;
   logic       rdy0, rdy1, xo0, xo1, xv0, xv1, fs0, fs1, bz0, bz1;

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP_CYCLES(0)) u0 (
      .clk(clk), .reset(reset), .in_data(din0), .in_valid(vin0), .in_ready(rdy0),
      .x_out(xo0), .x_valid(xv0), .frame_start(fs0), .busy(bz0));

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .GAP_CYCLES(2)) u1 (
      .clk(clk), .reset(reset), .in_data(din1), .in_valid(vin1), .in_ready(rdy1),
      .x_out(xo1), .x_valid(xv1), .frame_start(fs1), .busy(bz1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: remaining bits of the frame on the wire (current bit at [7])
   logic [7:0]  mbits [2];
   int          mcnt  [2];
   int          mgap  [2];
   logic        mfs   [2];
   // Upstream word source
   logic [7:0]  wq    [2][0:63];
   int          wh    [2];
   int          wt    [2];
   logic        vld   [2];
   logic        hold  [2];
   logic        acc   [2];
   logic [15:0] cap   [2];
   int          ncap  [2];

   task automatic chk(input string tag, input int i, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s[%0d]: observed %0h, expected %0h", tag, i, obs, exp);
      end
   endtask

   function automatic logic [7:0] order_bits(input int i, input logic [7:0] w);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) r[k] = w[7-k];
      return MSBF[i] ? w : r;
   endfunction

   function automatic logic exp_ready(input int i);
      return reset && ((mcnt[i] == 0 && mgap[i] == 0) || (mcnt[i] == 1 && GAPC[i] == 0));
   endfunction

   function automatic logic [4:0] obs_vec(input int i);
      return (i == 0) ? {xo0, xv0, fs0, bz0, rdy0} : {xo1, xv1, fs1, bz1, rdy1};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         mbits[i] = '0; mcnt[i] = 0; mgap[i] = 0; mfs[i] = 1'b0;
         wh[i] = 0; wt[i] = 0; vld[i] = 1'b0; acc[i] = 1'b0;
      end
   endtask

   task automatic push(input int i, input logic [7:0] w);
      wq[i][wt[i] % 64] = w;
      wt[i]++;
   endtask

   task automatic check_outputs(input int i);
      logic [4:0] o;
      o = obs_vec(i);
      chk("x_out",       i, 16'(o[4]), 16'((mcnt[i] > 0) ? mbits[i][7] : IDLEB[i]));
      chk("x_valid",     i, 16'(o[3]), 16'(mcnt[i] > 0));
      chk("frame_start", i, 16'(o[2]), 16'(mfs[i]));
      chk("busy",        i, 16'(o[1]), 16'(mcnt[i] > 0 || mgap[i] > 0));
      chk("in_ready",    i, 16'(o[0]), 16'(exp_ready(i)));
   endtask

   task automatic model_edge(input int i);
      logic popped;
      popped = 1'b0;
      if (mcnt[i] > 0) begin
         mbits[i] = mbits[i] << 1;
         mcnt[i]--;
         popped = 1'b1;
      end
      mfs[i] = 1'b0;
      if (mgap[i] > 0) mgap[i]--;
      if (popped && mcnt[i] == 0 && !acc[i] && GAPC[i] > 0) mgap[i] = GAPC[i];
      if (acc[i]) begin
         mbits[i] = order_bits(i, wq[i][wh[i] % 64]);
         mcnt[i]  = 8;
         mfs[i]   = 1'b1;
         wh[i]++;
         vld[i]   = 1'b0;
      end
   endtask

   // One clock: check at the falling edge, drive, then advance the model
   task automatic cycle();
      logic [7:0] d;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check_outputs(i);
         if (obs_vec(i)[3]) begin
            cap[i] = {cap[i][14:0], obs_vec(i)[4]};
            ncap[i]++;
         end
         if (!vld[i] && wh[i] != wt[i] && (hold[i] || $urandom_range(0, 2) == 0)) vld[i] = 1'b1;
         d = vld[i] ? wq[i][wh[i] % 64] : 8'($urandom);
         if (i == 0) begin din0 = d; vin0 = vld[i]; end
         else        begin din1 = d; vin1 = vld[i]; end
         acc[i] = vld[i] && exp_ready(i);
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_edge(i);
   endtask

   task automatic clear_cap();
      for (int i = 0; i < 2; i++) begin cap[i] = '0; ncap[i] = 0; end
   endtask

   initial begin
      int guard;
      reset = 1'b1; din0 = '0; din1 = '0; vin0 = 1'b0; vin1 = 1'b0;
      model_clear();
      hold[0] = 1'b1; hold[1] = 1'b1;
      clear_cap();

      // Async reset with no clock edge yet
      #3 reset = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) check_outputs(i);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) cycle();

      // Single MSB-first frame
      clear_cap();
      push(0, 8'b1011_0010);
      repeat (12) cycle();
      chk("t1_bits", 0, cap[0], 16'h00B2);
      chk("t1_count", 0, 16'(ncap[0]), 16'd8);

      // Back-to-back frames with in_valid held through the first frame
      clear_cap();
      push(0, 8'hA5);
      push(0, 8'h3C);
      repeat (20) cycle();
      chk("t2_bits", 0, cap[0], 16'hA53C);
      chk("t2_count", 0, 16'(ncap[0]), 16'd16);

      // LSB-first frames separated by the idle gap
      clear_cap();
      push(1, 8'h01);
      push(1, 8'hC5);
      repeat (30) cycle();
      chk("t4_bits", 1, cap[1], 16'h80A3);
      chk("t4_count", 1, 16'(ncap[1]), 16'd16);

      // Reset while bit 3 of 8'hFF is on the wire
      push(0, 8'hFF);
      guard = 0;
      while (mcnt[0] != 5 && guard < 20) begin
         cycle();
         guard++;
      end
      chk("t5_reach_bit3", 0, 16'(mcnt[0]), 16'd5);
      #2 reset = 1'b0;
      vin0 = 1'b0; vin1 = 1'b0;
      model_clear();
      #1;
      for (int i = 0; i < 2; i++) check_outputs(i);
      @(negedge clk);
      reset = 1'b1;
      repeat (4) cycle();

      // Random traffic with random valid timing
      hold[0] = 1'b0; hold[1] = 1'b0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 2; i++)
            if (wt[i] - wh[i] < 3 && $urandom_range(0, 3) == 0) push(i, 8'($urandom));
         cycle();
      end
      hold[0] = 1'b1; hold[1] = 1'b1;
      repeat (60) cycle();
      chk("drain0", 0, 16'(wt[0] - wh[0]), 16'd0);
      chk("drain1", 1, 16'(wt[1] - wh[1]), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
